// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the wave/work SRAM slot arbiter.
package sram_arb_pkg;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_ENG  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    localparam int          SLOTS_DEF    = 16;
    localparam logic [15:0] ENG_MASK_DEF = 16'h5555;

    function automatic int slot_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int SLOT_W = slot_w(SLOTS_DEF);

endpackage

// File: rtl/sram_slot_timer.sv
// Two-phase slot counter locked to the sound frame by SYNC rising edges.
module sram_slot_timer
    import sram_arb_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_sync,
    output logic [slot_w(SLOTS)-1:0]   o_slot,
    output logic [slot_w(SLOTS)-1:0]   o_next_slot,
    output logic                       o_enter_a,
    output logic                       o_misalign
);

    localparam int SW = slot_w(SLOTS);

    phase_t          r_phase;
    logic [SW-1:0]   r_slot;
    logic            r_sync_d;
    logic            r_pend;
    logic            r_mis;

    logic            w_rise;
    logic            w_enter_a;
    logic [SW-1:0]   w_inc;
    logic [SW-1:0]   w_next;

    assign w_rise    = i_sync & ~r_sync_d;
    assign w_enter_a = (r_phase == PH_B);
    assign w_inc     = r_slot + SW'(1);
    assign w_next    = r_pend ? '0 : w_inc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase  <= PH_A;
            r_slot   <= '0;
            r_sync_d <= 1'b0;
            r_pend   <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            r_sync_d <= i_sync;
            if (w_enter_a) begin
                r_phase <= PH_A;
                r_slot  <= w_next;
                // A forced restart that lands anywhere but the natural wrap is a frame slip
                if (r_pend && (w_inc != '0))
                    r_mis <= 1'b1;
                r_pend  <= w_rise;
            end else begin
                r_phase <= PH_B;
                if (w_rise)
                    r_pend <= 1'b1;
            end
        end
    end

    assign o_slot      = r_slot;
    assign o_next_slot = w_next;
    assign o_enter_a   = w_enter_a;
    assign o_misalign  = r_mis;

endmodule

// File: rtl/sram_slot_arbiter.sv
// Shares one SRAM between the voice engine and the CPU in fixed 2-clock slots;
// the engine owns masked slots, the CPU gets its own slots plus idle engine slots.
module sram_slot_arbiter
    import sram_arb_pkg::*;
#(
    parameter int               SLOTS    = SLOTS_DEF,
    parameter logic [SLOTS-1:0] ENG_MASK = ENG_MASK_DEF,
    parameter int               AW       = 11,
    parameter int               DW       = 8
) (
    input  logic                      XTAL_IN,
    input  logic                      RESET_IN,
    input  logic                      SYNC_IN,
    input  logic                      ENG_REQ_IN,
    input  logic                      ENG_WE_IN,
    input  logic [AW-1:0]             ENG_A_IN,
    input  logic [DW-1:0]             ENG_D_IN,
    output logic [DW-1:0]             ENG_D_OUT,
    output logic                      ENG_VALID_OUT,
    input  logic                      CPU_REQ_IN,
    input  logic                      CPU_WE_IN,
    input  logic [AW-1:0]             CPU_A_IN,
    input  logic [DW-1:0]             CPU_D_IN,
    output logic [DW-1:0]             CPU_D_OUT,
    output logic                      CPU_ACK_OUT,
    output logic [AW-1:0]             RAM_A_OUT,
    output logic [DW-1:0]             RAM_D_OUT,
    input  logic [DW-1:0]             RAM_D_IN,
    output logic                      RAM_D_IOM,
    output logic                      RAM_WR_OUT,
    output logic                      RAM_OE_OUT,
    output logic [slot_w(SLOTS)-1:0]  SLOT_OUT,
    output logic                      MISALIGN_OUT
);

    localparam int SW = slot_w(SLOTS);

    logic [SW-1:0]  w_slot;
    logic [SW-1:0]  w_next_slot;
    logic           w_enter_a;
    logic           w_misalign;

    sram_slot_timer #(
        .SLOTS (SLOTS)
    ) u_timer (
        .i_clk       (XTAL_IN),
        .i_rst_n     (RESET_IN),
        .i_sync      (SYNC_IN),
        .o_slot      (w_slot),
        .o_next_slot (w_next_slot),
        .o_enter_a   (w_enter_a),
        .o_misalign  (w_misalign)
    );

    owner_t         r_owner;
    logic           r_we;
    logic [AW-1:0]  r_ram_a;
    logic [DW-1:0]  r_ram_d;
    logic           r_iom;
    logic           r_wr_n;
    logic           r_oe_n;
    logic [DW-1:0]  r_eng_d;
    logic [DW-1:0]  r_cpu_d;
    logic           r_eng_valid;
    logic           r_cpu_ack;

    owner_t         w_grant;
    logic           w_cpu_elig;
    logic           w_sel_we;
    logic [AW-1:0]  w_sel_a;
    logic [DW-1:0]  w_sel_d;

    // The CPU completing at this edge sits out the slot being entered
    assign w_cpu_elig = (r_owner != OWN_CPU);

    always_comb begin
        w_grant  = OWN_NONE;
        w_sel_we = 1'b0;
        w_sel_a  = CPU_A_IN;
        w_sel_d  = CPU_D_IN;
        if (ENG_MASK[w_next_slot] && ENG_REQ_IN) begin
            w_grant  = OWN_ENG;
            w_sel_we = ENG_WE_IN;
            w_sel_a  = ENG_A_IN;
            w_sel_d  = ENG_D_IN;
        end else if (CPU_REQ_IN && w_cpu_elig) begin
            w_grant  = OWN_CPU;
            w_sel_we = CPU_WE_IN;
        end
    end

    always_ff @(posedge XTAL_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            r_owner     <= OWN_NONE;
            r_we        <= 1'b0;
            r_ram_a     <= '0;
            r_ram_d     <= '0;
            r_iom       <= 1'b0;
            r_wr_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_eng_d     <= '0;
            r_cpu_d     <= '0;
            r_eng_valid <= 1'b0;
            r_cpu_ack   <= 1'b0;
        end else begin
            r_eng_valid <= 1'b0;
            r_cpu_ack   <= 1'b0;
            if (w_enter_a) begin
                if (r_owner == OWN_ENG) begin
                    r_eng_valid <= 1'b1;
                    if (!r_we)
                        r_eng_d <= RAM_D_IN;
                end
                if (r_owner == OWN_CPU) begin
                    r_cpu_ack <= 1'b1;
                    if (!r_we)
                        r_cpu_d <= RAM_D_IN;
                end
                r_owner <= w_grant;
                r_we    <= w_sel_we;
                r_wr_n  <= 1'b1;
                if (w_grant != OWN_NONE) begin
                    r_ram_a <= w_sel_a;
                    r_ram_d <= w_sel_d;
                    r_iom   <= w_sel_we;
                    r_oe_n  <= w_sel_we;
                end else begin
                    r_iom  <= 1'b0;
                    r_oe_n <= 1'b1;
                end
            end else if ((r_owner != OWN_NONE) && r_we) begin
                r_wr_n <= 1'b0;
            end
        end
    end

    assign ENG_D_OUT     = r_eng_d;
    assign ENG_VALID_OUT = r_eng_valid;
    assign CPU_D_OUT     = r_cpu_d;
    assign CPU_ACK_OUT   = r_cpu_ack;
    assign RAM_A_OUT     = r_ram_a;
    assign RAM_D_OUT     = r_ram_d;
    assign RAM_D_IOM     = r_iom;
    assign RAM_WR_OUT    = r_wr_n;
    assign RAM_OE_OUT    = r_oe_n;
    assign SLOT_OUT      = w_slot;
    assign MISALIGN_OUT  = w_misalign;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter with a behavioural 2K x 8 SRAM.
module tb_sram_slot_arbiter;

    logic        XTAL_IN;
    logic        RESET_IN;
    logic        SYNC_IN;
    logic        ENG_REQ_IN;
    logic        ENG_WE_IN;
    logic [10:0] ENG_A_IN;
    logic [7:0]  ENG_D_IN;
    logic [7:0]  ENG_D_OUT;
    logic        ENG_VALID_OUT;
    logic        CPU_REQ_IN;
    logic        CPU_WE_IN;
    logic [10:0] CPU_A_IN;
    logic [7:0]  CPU_D_IN;
    logic [7:0]  CPU_D_OUT;
    logic        CPU_ACK_OUT;
    logic [10:0] RAM_A_OUT;
    logic [7:0]  RAM_D_OUT;
    logic [7:0]  RAM_D_IN;
    logic        RAM_D_IOM;
    logic        RAM_WR_OUT;
    logic        RAM_OE_OUT;
    logic [3:0]  SLOT_OUT;
    logic        MISALIGN_OUT;

    sram_slot_arbiter dut (
        .XTAL_IN       (XTAL_IN),
        .RESET_IN      (RESET_IN),
        .SYNC_IN       (SYNC_IN),
        .ENG_REQ_IN    (ENG_REQ_IN),
        .ENG_WE_IN     (ENG_WE_IN),
        .ENG_A_IN      (ENG_A_IN),
        .ENG_D_IN      (ENG_D_IN),
        .ENG_D_OUT     (ENG_D_OUT),
        .ENG_VALID_OUT (ENG_VALID_OUT),
        .CPU_REQ_IN    (CPU_REQ_IN),
        .CPU_WE_IN     (CPU_WE_IN),
        .CPU_A_IN      (CPU_A_IN),
        .CPU_D_IN      (CPU_D_IN),
        .CPU_D_OUT     (CPU_D_OUT),
        .CPU_ACK_OUT   (CPU_ACK_OUT),
        .RAM_A_OUT     (RAM_A_OUT),
        .RAM_D_OUT     (RAM_D_OUT),
        .RAM_D_IN      (RAM_D_IN),
        .RAM_D_IOM     (RAM_D_IOM),
        .RAM_WR_OUT    (RAM_WR_OUT),
        .RAM_OE_OUT    (RAM_OE_OUT),
        .SLOT_OUT      (SLOT_OUT),
        .MISALIGN_OUT  (MISALIGN_OUT)
    );

    initial XTAL_IN = 1'b0;
    always #5 XTAL_IN = ~XTAL_IN;

    // Behavioural SRAM: latches on the edge that ends a low WR strobe
    logic [7:0] mem [0:2047];
    always @(posedge XTAL_IN)
        if (!RAM_WR_OUT && RAM_D_IOM)
            mem[RAM_A_OUT] <= RAM_D_OUT;
    assign RAM_D_IN = RAM_OE_OUT ? 8'h00 : mem[RAM_A_OUT];

    typedef struct {
        int er, ewe, ea, ed;
        int cr, cwe, ca, cd;
        int slot, a, d, iom, wr, oe, ev, ack, edo, cdo;
    } vec_t;

    vec_t vt [21];
    int   n_cmp;
    int   n_err;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge XTAL_IN);
        @(negedge XTAL_IN);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //          er ewe ea      ed     cr cwe ca      cd     slot a       d      iom wr oe ev ack edo    cdo
        vt[0]  = '{1, 1, 'h123, 'hA5, 0, 0, 'h000, 'h00, 0,  'h123, 'hA5, 1, 1, 1, 0, 0, 'h00, 'h00};
        vt[1]  = '{0, 0, 'h000, 'h00, 1, 0, 'h123, 'h00, 0,  'h123, 'hA5, 1, 0, 1, 0, 0, 'h00, 'h00};
        vt[2]  = '{0, 0, 'h000, 'h00, 1, 0, 'h123, 'h00, 1,  'h123, 'h00, 0, 1, 0, 1, 0, 'h00, 'h00};
        vt[3]  = '{0, 0, 'h000, 'h00, 1, 0, 'h123, 'h00, 1,  'h123, 'h00, 0, 1, 0, 0, 0, 'h00, 'h00};
        vt[4]  = '{0, 0, 'h000, 'h00, 1, 0, 'h123, 'h00, 2,  'h123, 'h00, 0, 1, 1, 0, 1, 'h00, 'hA5};
        vt[5]  = '{0, 0, 'h000, 'h00, 1, 1, 'h0F0, 'h3C, 2,  'h123, 'h00, 0, 1, 1, 0, 0, 'h00, 'hA5};
        vt[6]  = '{0, 0, 'h000, 'h00, 1, 1, 'h0F0, 'h3C, 3,  'h0F0, 'h3C, 1, 1, 1, 0, 0, 'h00, 'hA5};
        vt[7]  = '{0, 0, 'h000, 'h00, 1, 1, 'h0F0, 'h3C, 3,  'h0F0, 'h3C, 1, 0, 1, 0, 0, 'h00, 'hA5};
        vt[8]  = '{0, 0, 'h000, 'h00, 1, 1, 'h0F0, 'h3C, 4,  'h0F0, 'h3C, 0, 1, 1, 0, 1, 'h00, 'hA5};
        vt[9]  = '{0, 0, 'h000, 'h00, 1, 0, 'h0F0, 'h00, 4,  'h0F0, 'h3C, 0, 1, 1, 0, 0, 'h00, 'hA5};
        vt[10] = '{0, 0, 'h000, 'h00, 1, 0, 'h0F0, 'h00, 5,  'h0F0, 'h00, 0, 1, 0, 0, 0, 'h00, 'hA5};
        vt[11] = '{0, 0, 'h000, 'h00, 0, 0, 'h000, 'h00, 5,  'h0F0, 'h00, 0, 1, 0, 0, 0, 'h00, 'hA5};
        vt[12] = '{1, 0, 'h0F0, 'h00, 0, 0, 'h000, 'h00, 6,  'h0F0, 'h00, 0, 1, 0, 0, 1, 'h00, 'h3C};
        vt[13] = '{0, 0, 'h000, 'h00, 0, 0, 'h000, 'h00, 6,  'h0F0, 'h00, 0, 1, 0, 0, 0, 'h00, 'h3C};
        vt[14] = '{0, 0, 'h000, 'h00, 0, 0, 'h000, 'h00, 7,  'h0F0, 'h00, 0, 1, 1, 1, 0, 'h3C, 'h3C};
        vt[15] = '{1, 1, 'h7FF, 'hFF, 1, 0, 'h7FF, 'h00, 7,  'h0F0, 'h00, 0, 1, 1, 0, 0, 'h3C, 'h3C};
        vt[16] = '{1, 1, 'h7FF, 'hFF, 1, 0, 'h7FF, 'h00, 8,  'h7FF, 'hFF, 1, 1, 1, 0, 0, 'h3C, 'h3C};
        vt[17] = '{0, 0, 'h000, 'h00, 1, 0, 'h7FF, 'h00, 8,  'h7FF, 'hFF, 1, 0, 1, 0, 0, 'h3C, 'h3C};
        vt[18] = '{0, 0, 'h000, 'h00, 1, 0, 'h7FF, 'h00, 9,  'h7FF, 'h00, 0, 1, 0, 1, 0, 'h3C, 'h3C};
        vt[19] = '{0, 0, 'h000, 'h00, 1, 0, 'h7FF, 'h00, 9,  'h7FF, 'h00, 0, 1, 0, 0, 0, 'h3C, 'h3C};
        vt[20] = '{0, 0, 'h000, 'h00, 0, 0, 'h000, 'h00, 10, 'h7FF, 'h00, 0, 1, 1, 0, 1, 'h3C, 'hFF};

        RESET_IN   = 1'b0;
        SYNC_IN    = 1'b0;
        ENG_REQ_IN = 1'b0;
        ENG_WE_IN  = 1'b0;
        ENG_A_IN   = '0;
        ENG_D_IN   = '0;
        CPU_REQ_IN = 1'b0;
        CPU_WE_IN  = 1'b0;
        CPU_A_IN   = '0;
        CPU_D_IN   = '0;

        repeat (3) tick();
        chk("rst.wr",   int'(RAM_WR_OUT), 1);
        chk("rst.oe",   int'(RAM_OE_OUT), 1);
        chk("rst.iom",  int'(RAM_D_IOM), 0);
        chk("rst.slot", int'(SLOT_OUT), 0);
        chk("rst.a",    int'(RAM_A_OUT), 0);
        chk("rst.ev",   int'(ENG_VALID_OUT), 0);
        chk("rst.ack",  int'(CPU_ACK_OUT), 0);
        chk("rst.mis",  int'(MISALIGN_OUT), 0);

        RESET_IN = 1'b1;
        repeat (10) tick();
        chk("sync.pre_slot", int'(SLOT_OUT), 5);
        SYNC_IN = 1'b1;
        tick();
        chk("sync.phb_slot", int'(SLOT_OUT), 5);
        chk("sync.phb_mis",  int'(MISALIGN_OUT), 0);

        for (int i = 0; i < 21; i++) begin
            ENG_REQ_IN = vt[i].er[0];
            ENG_WE_IN  = vt[i].ewe[0];
            ENG_A_IN   = 11'(vt[i].ea);
            ENG_D_IN   = 8'(vt[i].ed);
            CPU_REQ_IN = vt[i].cr[0];
            CPU_WE_IN  = vt[i].cwe[0];
            CPU_A_IN   = 11'(vt[i].ca);
            CPU_D_IN   = 8'(vt[i].cd);
            tick();
            chk($sformatf("v%0d.slot", i), int'(SLOT_OUT), vt[i].slot);
            chk($sformatf("v%0d.a", i),    int'(RAM_A_OUT), vt[i].a);
            chk($sformatf("v%0d.d", i),    int'(RAM_D_OUT), vt[i].d);
            chk($sformatf("v%0d.iom", i),  int'(RAM_D_IOM), vt[i].iom);
            chk($sformatf("v%0d.wr", i),   int'(RAM_WR_OUT), vt[i].wr);
            chk($sformatf("v%0d.oe", i),   int'(RAM_OE_OUT), vt[i].oe);
            chk($sformatf("v%0d.ev", i),   int'(ENG_VALID_OUT), vt[i].ev);
            chk($sformatf("v%0d.ack", i),  int'(CPU_ACK_OUT), vt[i].ack);
            chk($sformatf("v%0d.edo", i),  int'(ENG_D_OUT), vt[i].edo);
            chk($sformatf("v%0d.cdo", i),  int'(CPU_D_OUT), vt[i].cdo);
            chk($sformatf("v%0d.mis", i),  int'(MISALIGN_OUT), 1);
        end

        // CPU write in slot 11, reset pulled mid phase B
        SYNC_IN    = 1'b0;
        CPU_REQ_IN = 1'b1;
        CPU_WE_IN  = 1'b1;
        CPU_A_IN   = 11'h055;
        CPU_D_IN   = 8'h77;
        tick();
        tick();
        chk("rw.a_slot", int'(SLOT_OUT), 11);
        chk("rw.a_addr", int'(RAM_A_OUT), 'h055);
        chk("rw.a_iom",  int'(RAM_D_IOM), 1);
        chk("rw.a_wr",   int'(RAM_WR_OUT), 1);
        CPU_REQ_IN = 1'b0;
        tick();
        chk("rw.b_wr",   int'(RAM_WR_OUT), 0);
        RESET_IN = 1'b0;
        #1;
        chk("rw.async_wr",   int'(RAM_WR_OUT), 1);
        chk("rw.async_iom",  int'(RAM_D_IOM), 0);
        chk("rw.async_slot", int'(SLOT_OUT), 0);
        chk("rw.async_mis",  int'(MISALIGN_OUT), 0);
        chk("rw.async_cdo",  int'(CPU_D_OUT), 0);
        tick();
        chk("rw.no_ack", int'(CPU_ACK_OUT), 0);
        RESET_IN = 1'b1;
        tick();
        chk("rw.rel_slot", int'(SLOT_OUT), 0);
        chk("rw.rel_ack",  int'(CPU_ACK_OUT), 0);
        chk("rw.rel_mis",  int'(MISALIGN_OUT), 0);
        tick();
        chk("rw.rel_slot1", int'(SLOT_OUT), 1);
        chk("rw.rel_idle",  int'(RAM_WR_OUT), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_slot_arbiter.md
Name: sram_slot_arbiter

Overview:
- Time-slot arbiter sharing one 2K x 8 wave/work SRAM (IC12/IC13 style) between two requesters: the voice engine and the CPU register interface.
- Engine owns fixed slots locked to the sound frame via SYNC_IN. The CPU is served in its own slots and in engine slots the engine leaves idle.
- Drives the SRAM strobes directly, with the same active-low WR/OE and D_IOM convention as the existing SRAM hookups.

Parameters:
- SLOTS, 16, slots per frame; power of two, 2..64.
- ENG_MASK, 16'h5555, bit i=1 means the engine owns slot i; at least one bit must be 0.
- AW, 11, SRAM address width.
- DW, 8, SRAM data width.

Ports:
- XTAL_IN  in  1  system clock (rising edge).
- RESET_IN  in  1  asynchronous active-low reset.
- SYNC_IN  in  1  frame sync from IC9; rising edge realigns slots.
- ENG_REQ_IN  in  1  engine access request for the current slot.
- ENG_WE_IN  in  1  1=write, 0=read.
- ENG_A_IN  in  AW  engine address.
- ENG_D_IN  in  DW  engine write data.
- ENG_D_OUT  out  DW  engine read data.
- ENG_VALID_OUT  out  1  1-clk completion pulse.
- CPU_REQ_IN  in  1  CPU request; held until ACK.
- CPU_WE_IN  in  1  1=write.
- CPU_A_IN  in  AW  CPU address.
- CPU_D_IN  in  DW  CPU write data.
- CPU_D_OUT  out  DW  CPU read data.
- CPU_ACK_OUT  out  1  1-clk completion pulse.
- RAM_A_OUT  out  AW  SRAM address.
- RAM_D_OUT  out  DW  SRAM write data.
- RAM_D_IN  in  DW  SRAM read data.
- RAM_D_IOM  out  1  1=arbiter drives the data bus.
- RAM_WR_OUT  out  1  write strobe, active low.
- RAM_OE_OUT  out  1  output enable, active low.
- SLOT_OUT  out  log2(SLOTS)  current slot index.
- MISALIGN_OUT  out  1  sticky; SYNC edge seen off frame boundary.

Behaviour:
- Reset values:
  - Slot 0, phase A.
  - RAM_WR_OUT=1, RAM_OE_OUT=1, RAM_D_IOM=0.
  - RAM_A_OUT=0, RAM_D_OUT=0, ENG_D_OUT=0, CPU_D_OUT=0.
  - ENG_VALID_OUT=0, CPU_ACK_OUT=0, MISALIGN_OUT=0, SYNC pending cleared.
  - Reset is asynchronous, so an in-progress access is dropped with no ACK/VALID.
- Slot structure: each slot is 2 clocks, phase A then phase B. SLOT_OUT increments at the A boundary and wraps SLOTS-1 -> 0.
- Grant, evaluated at the clock edge that enters phase A (g = slot being entered):
  - Engine slot (ENG_MASK[g]=1):
    - ENG_REQ_IN=1 -> grant engine.
    - Otherwise CPU_REQ_IN=1 and CPU eligible -> grant CPU.
  - CPU slot (ENG_MASK[g]=0): CPU_REQ_IN=1 and eligible -> grant CPU. The engine never uses CPU slots.
  - CPU eligibility: the CPU is ineligible for the slot immediately following a slot in which it completed an access (cooldown), which prevents double service of a held request.
  - No grant -> idle slot.
- Granted slot, phase A:
  - Address and data registered onto RAM_A_OUT and RAM_D_OUT.
  - Write: RAM_D_IOM=1, RAM_WR_OUT=1, RAM_OE_OUT=1.
  - Read: RAM_D_IOM=0, RAM_OE_OUT=0.
- Granted slot, phase B:
  - Write: RAM_WR_OUT=0 for this phase only, RAM_D_IOM stays 1.
  - Read: RAM_OE_OUT=0; RAM_D_IN is sampled at the edge ending phase B.
- Completion, at the edge ending phase B:
  - The owner's VALID/ACK goes high for exactly the next clock.
  - Read data is loaded into ENG_D_OUT or CPU_D_OUT and held until the next read completion for that requester.
  - Write completions leave D_OUT unchanged.
- Idle slot: RAM_WR_OUT=RAM_OE_OUT=1, RAM_D_IOM=0, RAM_A_OUT holds its last value.
- Latency:
  - Access = 2 clocks from grant to completion; ACK is visible 2 clocks after the grant edge.
  - Worst-case CPU wait is bounded by the longest run of engine-owned slots plus cooldown, each slot costing 2 clocks.
- Request withdrawal: CPU_REQ_IN dropped before grant withdraws the request. Once granted, the access completes and ACK fires regardless.
- SYNC_IN handling:
  - Rising edge is detected with a 1-clk registered compare and sets sync-pending.
  - At the next phase-A boundary the slot is forced to 0 and pending is cleared; an in-flight phase B always completes first.
  - If the forced slot was not already going to be 0, MISALIGN_OUT=1 (sticky until reset).
  - A SYNC edge arriving while a previous one is still pending is merged.
- Data widths: all pass-through, no arithmetic. SLOT_OUT is an unsigned modulo-SLOTS counter.

Decomposition:
- Package sram_arb_pkg holds:
  - phase_t enum {PH_A, PH_B}.
  - owner_t enum {OWN_NONE, OWN_ENG, OWN_CPU}.
  - SLOT_W function/constant.
  - Default ENG_MASK.
- Sub-module sram_slot_timer contains the phase/slot counter, SYNC edge detect, pending flag and MISALIGN_OUT. The arbiter top instantiates it and holds the grant and strobe logic.

Test Plan:
- Reset, release, SYNC_IN rising at slot 5 phase A -> slot 0 begins at the next A boundary; MISALIGN_OUT=1 and stays set; strobes high and D_IOM=0 throughout reset.
- Engine write in slot 0, A=11'h123, D=8'hA5 -> RAM_A_OUT=11'h123 and RAM_D_IOM=1 for 2 clocks; RAM_WR_OUT low only in phase B; ENG_VALID_OUT pulses once.
- CPU read of 11'h123 held from slot 0 -> served in slot 1 with RAM_OE_OUT low for 2 clocks; CPU_ACK_OUT pulses with CPU_D_OUT=8'hA5, exactly one ACK.
- CPU request held continuously while the engine is idle -> served in slots 1, 3, 5 (cooldown skips 2, 4); with ENG_REQ_IN=1 on even slots, CPU served in odd slots only, no strobe overlap.
- Engine and CPU both request in engine slot 2 -> engine wins; CPU served in slot 3.
- RESET_IN low mid phase B of a write -> RAM_WR_OUT=1 asynchronously, no VALID, slot 0 after release.
